ofdm_qpsk_demap: RTL and testbench



---
 rtl/ofdm_demap_pkg.sv | 31 +++
 rtl/ofdm_qpsk_demap_classifier.sv | 48 ++++
 rtl/ofdm_qpsk_demap.sv | 199 +++++++++++++++++++
 tb/tb_ofdm_qpsk_demap.sv | 327 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ofdm_demap_pkg.sv
// Shared constants and types for the OFDM QPSK demapper.
// Optional pilot export is controlled by the macro OFDM_DEMAP_PILOT_OUT_EN.
package ofdm_demap_pkg;

    localparam int N_FFT         = 64;
    localparam int BYTES_PER_SYM = 12;

    // Pilot bins, named by their logical subcarrier position
    localparam logic [7:0] PILOT_M21 = 8'd43;
    localparam logic [7:0] PILOT_M7  = 8'd57;
    localparam logic [7:0] PILOT_P7  = 8'd7;
    localparam logic [7:0] PILOT_P21 = 8'd21;

    // Guard band of null bins between the positive and negative halves
    localparam logic [7:0] NULL_LO  = 8'd27;
    localparam logic [7:0] NULL_HI  = 8'd37;
    localparam logic [7:0] LAST_BIN = 8'(N_FFT - 1);

    typedef enum logic [1:0] {
        CLS_NULL,
        CLS_PILOT,
        CLS_DPOS,
        CLS_DNEG
    } bin_class_e;

    typedef enum logic {
        ST_IDLE,
        ST_COLLECT
    } demap_state_e;

endpackage

// File: rtl/ofdm_qpsk_demap_classifier.sv
// Combinational bin classifier: maps an FFT bin index to its class,
// the pilot slot in logical order, and the data ordinal within its half.
module ofdm_bin_classifier
    import ofdm_demap_pkg::*;
(
    input  logic [7:0]  index_i,
    output bin_class_e  binClass_o,
    output logic [1:0]  pilotSel_o,
    output logic [4:0]  dataOrd_o
);

    // Decode the index; ordinals skip the pilots embedded in each half
    always_comb begin
        binClass_o = CLS_NULL;
        pilotSel_o = 2'd0;
        dataOrd_o  = 5'd0;
        if (index_i == PILOT_M21) begin
            binClass_o = CLS_PILOT;
            pilotSel_o = 2'd0;
        end else if (index_i == PILOT_M7) begin
            binClass_o = CLS_PILOT;
            pilotSel_o = 2'd1;
        end else if (index_i == PILOT_P7) begin
            binClass_o = CLS_PILOT;
            pilotSel_o = 2'd2;
        end else if (index_i == PILOT_P21) begin
            binClass_o = CLS_PILOT;
            pilotSel_o = 2'd3;
        end else if (index_i >= 8'd1 && index_i < NULL_LO) begin
            binClass_o = CLS_DPOS;
            if (index_i < PILOT_P7)
                dataOrd_o = 5'(index_i - 8'd1);
            else if (index_i < PILOT_P21)
                dataOrd_o = 5'(index_i - 8'd2);
            else
                dataOrd_o = 5'(index_i - 8'd3);
        end else if (index_i > NULL_HI && index_i <= LAST_BIN) begin
            binClass_o = CLS_DNEG;
            if (index_i < PILOT_M21)
                dataOrd_o = 5'(index_i - 8'd38);
            else if (index_i < PILOT_M7)
                dataOrd_o = 5'(index_i - 8'd39);
            else
                dataOrd_o = 5'(index_i - 8'd40);
        end
    end

endmodule

// File: rtl/ofdm_qpsk_demap.sv
// QPSK hard-decision demapper behind the FFT. Negative-half bytes are sent
// as they complete; positive-half bits are collected and drained after bin 63.
// Define OFDM_DEMAP_PILOT_OUT_EN to export in-sequence pilot bins.
module ofdm_qpsk_demap
    import ofdm_demap_pkg::*;
(
    input  logic        clk_20m,
    input  logic        Rst_n_0,
    input  logic [7:0]  fft_dout_re,
    input  logic [7:0]  fft_dout_im,
    input  logic [7:0]  fft_dout_index,
    input  logic        fft_dout_vld,
    output logic [7:0]  dout,
    output logic        dout_vld,
    output logic        dout_sym_last,
    output logic [7:0]  sym_cnt,
    output logic        idx_err
`ifdef OFDM_DEMAP_PILOT_OUT_EN
    ,
    output logic [7:0]  pilot_re,
    output logic [7:0]  pilot_im,
    output logic [1:0]  pilot_sel,
    output logic        pilot_vld
`endif
);

    demap_state_e state_q, state_d;
    logic [5:0]   expIdx_q, expIdx_d;
    logic [47:0]  collect_q, collect_d;
    logic [47:0]  drain_q, drain_d;
    logic [2:0]   drainCnt_q, drainCnt_d;
    logic [5:0]   negAcc_q, negAcc_d;
    logic [7:0]   dout_q, dout_d;
    logic         doutVld_q, doutVld_d;
    logic         symLast_q, symLast_d;
    logic [7:0]   symCnt_q, symCnt_d;
    logic         idxErr_q, idxErr_d;

    logic         accept;
    logic         symEnd;
    bin_class_e   binClass;
    logic [1:0]   pilotSel;
    logic [4:0]   binOrd;
    logic [1:0]   pair;
    logic [5:0]   posBit;

    ofdm_bin_classifier u_classifier (
        .index_i    (fft_dout_index),
        .binClass_o (binClass),
        .pilotSel_o (pilotSel),
        .dataOrd_o  (binOrd)
    );

    // Sign-bit slicer: non-negative maps to 1
    assign pair   = {~fft_dout_re[7], ~fft_dout_im[7]};
    assign posBit = 6'd47 - {binOrd, 1'b0};

    // Index sequencing: accept in-order bins, flag and abort on a break
    always_comb begin
        state_d  = state_q;
        expIdx_d = expIdx_q;
        accept   = 1'b0;
        symEnd   = 1'b0;
        idxErr_d = 1'b0;
        if (fft_dout_vld) begin
            case (state_q)
                ST_IDLE: begin
                    if (fft_dout_index == 8'd0) begin
                        accept   = 1'b1;
                        state_d  = ST_COLLECT;
                        expIdx_d = 6'd1;
                    end
                end
                ST_COLLECT: begin
                    if (fft_dout_index == {2'b00, expIdx_q}) begin
                        accept = 1'b1;
                        if (expIdx_q == 6'd63) begin
                            symEnd  = 1'b1;
                            state_d = ST_IDLE;
                        end else begin
                            expIdx_d = expIdx_q + 6'd1;
                        end
                    end else begin
                        idxErr_d = 1'b1;
                        if (fft_dout_index == 8'd0) begin
                            accept   = 1'b1;
                            expIdx_d = 6'd1;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // Datapath: pack data pairs, emit negative bytes, run the drain
    always_comb begin
        collect_d  = collect_q;
        drain_d    = drain_q;
        drainCnt_d = drainCnt_q;
        negAcc_d   = negAcc_q;
        dout_d     = dout_q;
        doutVld_d  = 1'b0;
        symLast_d  = 1'b0;
        symCnt_d   = symCnt_q;
        if (drainCnt_q != 3'd0) begin
            dout_d     = drain_q[47:40];
            doutVld_d  = 1'b1;
            drain_d    = {drain_q[39:0], 8'h00};
            drainCnt_d = drainCnt_q - 3'd1;
            if (drainCnt_q == 3'd1) begin
                symLast_d = 1'b1;
                symCnt_d  = symCnt_q + 8'd1;
            end
        end
        if (accept && binClass == CLS_DPOS)
            collect_d[posBit -: 2] = pair;
        if (accept && binClass == CLS_DNEG) begin
            negAcc_d = {negAcc_q[3:0], pair};
            if (binOrd[1:0] == 2'b11) begin
                dout_d    = {negAcc_q, pair};
                doutVld_d = 1'b1;
            end
        end
        if (symEnd) begin
            drain_d    = collect_q;
            drainCnt_d = 3'd6;
        end
    end

    // State and datapath registers
    always_ff @(posedge clk_20m or negedge Rst_n_0) begin
        if (!Rst_n_0) begin
            state_q    <= ST_IDLE;
            expIdx_q   <= 6'd0;
            collect_q  <= 48'd0;
            drain_q    <= 48'd0;
            drainCnt_q <= 3'd0;
            negAcc_q   <= 6'd0;
            dout_q     <= 8'd0;
            doutVld_q  <= 1'b0;
            symLast_q  <= 1'b0;
            symCnt_q   <= 8'd0;
            idxErr_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            expIdx_q   <= expIdx_d;
            collect_q  <= collect_d;
            drain_q    <= drain_d;
            drainCnt_q <= drainCnt_d;
            negAcc_q   <= negAcc_d;
            dout_q     <= dout_d;
            doutVld_q  <= doutVld_d;
            symLast_q  <= symLast_d;
            symCnt_q   <= symCnt_d;
            idxErr_q   <= idxErr_d;
        end
    end

    assign dout          = dout_q;
    assign dout_vld      = doutVld_q;
    assign dout_sym_last = symLast_q;
    assign sym_cnt       = symCnt_q;
    assign idx_err       = idxErr_q;

`ifdef OFDM_DEMAP_PILOT_OUT_EN
    logic [7:0] pilotRe_q, pilotIm_q;
    logic [1:0] pilotSel_q;
    logic       pilotVld_q;

    // Register in-sequence pilot bins with their logical slot
    always_ff @(posedge clk_20m or negedge Rst_n_0) begin
        if (!Rst_n_0) begin
            pilotRe_q  <= 8'd0;
            pilotIm_q  <= 8'd0;
            pilotSel_q <= 2'd0;
            pilotVld_q <= 1'b0;
        end else begin
            pilotVld_q <= accept && (binClass == CLS_PILOT);
            if (accept && binClass == CLS_PILOT) begin
                pilotRe_q  <= fft_dout_re;
                pilotIm_q  <= fft_dout_im;
                pilotSel_q <= pilotSel;
            end
        end
    end

    assign pilot_re  = pilotRe_q;
    assign pilot_im  = pilotIm_q;
    assign pilot_sel = pilotSel_q;
    assign pilot_vld = pilotVld_q;
`else
    logic unusedPilot;
    assign unusedPilot = ^{pilotSel, fft_dout_re[6:0], fft_dout_im[6:0]};
`endif

endmodule

// File: tb/tb_ofdm_qpsk_demap.sv
// Self-checking bench for ofdm_qpsk_demap: table-driven symbols plus
// hand-written sequences for errors, timing, gaps and reset mid-drain.
module tb_ofdm_qpsk_demap;

    logic              clk_20m = 1'b0;
    logic              Rst_n_0 = 1'b0;
    logic signed [7:0] fft_dout_re = '0;
    logic signed [7:0] fft_dout_im = '0;
    logic [7:0]        fft_dout_index = '0;
    logic              fft_dout_vld = 1'b0;
    logic [7:0]        dout;
    logic              dout_vld;
    logic              dout_sym_last;
    logic [7:0]        sym_cnt;
    logic              idx_err;
`ifdef OFDM_DEMAP_PILOT_OUT_EN
    logic [7:0]        pilot_re, pilot_im;
    logic [1:0]        pilot_sel;
    logic              pilot_vld;
`endif

    ofdm_qpsk_demap dut (
        .clk_20m        (clk_20m),
        .Rst_n_0        (Rst_n_0),
        .fft_dout_re    (fft_dout_re),
        .fft_dout_im    (fft_dout_im),
        .fft_dout_index (fft_dout_index),
        .fft_dout_vld   (fft_dout_vld),
        .dout           (dout),
        .dout_vld       (dout_vld),
        .dout_sym_last  (dout_sym_last),
        .sym_cnt        (sym_cnt),
        .idx_err        (idx_err)
`ifdef OFDM_DEMAP_PILOT_OUT_EN
        ,
        .pilot_re       (pilot_re),
        .pilot_im       (pilot_im),
        .pilot_sel      (pilot_sel),
        .pilot_vld      (pilot_vld)
`endif
    );

    always #25 clk_20m = ~clk_20m;

    typedef struct {
        logic [7:0] data;
        logic       last;
    } exp_t;

    typedef struct {
        logic signed [7:0] reNeg;
        logic signed [7:0] imNeg;
        logic signed [7:0] rePos;
        logic signed [7:0] imPos;
        logic [7:0]        expNeg;
        logic [7:0]        expPos;
        bit                gaps;
    } vec_t;

    exp_t              expQ[$];
    int                vldCyc[$];
    logic [17:0]       pilotQ[$];
    vec_t              vecs[6];
    logic signed [7:0] symRe[64];
    logic signed [7:0] symIm[64];
    int                checks = 0;
    int                failures = 0;
    int                errCount = 0;
    int                cyc = 0;
    int                t63 = 0;
    int                expSymCnt = 0;

    always @(posedge clk_20m) cyc <= cyc + 1;

    // Scoreboard: every output byte must match the head of the queue
    always @(negedge clk_20m) begin
        if (Rst_n_0 && dout_vld) begin
            vldCyc.push_back(cyc);
            checks++;
            if (expQ.size() == 0) begin
                failures++;
                $display("[TB] FAIL unexpected_byte actual=%02h expected=none", dout);
            end else begin
                exp_t e;
                e = expQ.pop_front();
                if (dout !== e.data || dout_sym_last !== e.last) begin
                    failures++;
                    $display("[TB] FAIL byte actual=%02h/last%0b expected=%02h/last%0b",
                             dout, dout_sym_last, e.data, e.last);
                end
            end
        end
        if (Rst_n_0 && idx_err) errCount++;
`ifdef OFDM_DEMAP_PILOT_OUT_EN
        if (Rst_n_0 && pilot_vld) pilotQ.push_back({pilot_sel, pilot_re, pilot_im});
`endif
    end

    initial begin
        #(50 * 50000);
        $display("[TB] FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%0d expected=%0d", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input int idx, input logic signed [7:0] re,
                                 input logic signed [7:0] im);
        fft_dout_index = idx[7:0];
        fft_dout_re    = re;
        fft_dout_im    = im;
        fft_dout_vld   = 1'b1;
        if (idx == 63) t63 = cyc;
        @(posedge clk_20m);
        #1;
        fft_dout_vld = 1'b0;
    endtask

    task automatic idleCycles(input int n);
        fft_dout_vld = 1'b0;
        repeat (n) @(posedge clk_20m);
        #1;
    endtask

    task automatic driveSymbol(input bit gaps);
        for (int b = 0; b < 64; b++) begin
            applyStimulus(b, symRe[b], symIm[b]);
            if (gaps) idleCycles(1);
        end
    endtask

    function automatic bit isData(input int b);
        if (b == 0 || (b >= 27 && b <= 37)) return 1'b0;
        if (b == 7 || b == 21 || b == 43 || b == 57) return 1'b0;
        return 1'b1;
    endfunction

    // Reference packer: walk logical order -26..+26 and pack pairs MSB-first
    task automatic pushModel(input int maxBytes);
        logic [7:0] acc;
        int         n;
        int         nBytes;
        acc    = 8'h00;
        n      = 0;
        nBytes = 0;
        for (int k = 0; k < 52; k++) begin
            int b;
            b = (k < 26) ? (38 + k) : (k - 25);
            if (isData(b) && nBytes < maxBytes) begin
                acc = {acc[5:0], ~symRe[b][7], ~symIm[b][7]};
                n++;
                if (n % 4 == 0) begin
                    expQ.push_back('{data: acc, last: (n == 48)});
                    nBytes++;
                end
            end
        end
    endtask

    task automatic waitDrain(input string name);
        int k;
        k = 0;
        while (expQ.size() != 0 && k < 100) begin
            @(posedge clk_20m);
            #1;
            k++;
        end
        checks++;
        if (expQ.size() != 0) begin
            failures++;
            $display("[TB] FAIL %s_drain actual=%0d_pending expected=0_pending", name, expQ.size());
            expQ.delete();
        end
        idleCycles(4);
    endtask

    task automatic fillUniform(input logic signed [7:0] reN, input logic signed [7:0] imN,
                               input logic signed [7:0] reP, input logic signed [7:0] imP);
        for (int b = 0; b < 64; b++) begin
            if (!isData(b)) begin
                symRe[b] = -8'sd100;
                symIm[b] = 8'sd100;
            end else if (b >= 38) begin
                symRe[b] = reN;
                symIm[b] = imN;
            end else begin
                symRe[b] = reP;
                symIm[b] = imP;
            end
        end
    endtask

    initial begin
        int e0;
        vecs[0] = '{ 8'sd20,  -8'sd20,   8'sd20,  -8'sd20,  8'hAA, 8'hAA, 1'b0};
        vecs[1] = '{ 8'sd5,    8'sd5,   -8'sd5,   -8'sd5,   8'hFF, 8'h00, 1'b0};
        vecs[2] = '{-8'sd1,    8'sd1,    8'sd1,   -8'sd1,   8'h55, 8'hAA, 1'b0};
        vecs[3] = '{ 8'sd127, -8'sd128, -8'sd128,  8'sd127, 8'hAA, 8'h55, 1'b0};
        vecs[4] = '{ 8'sd0,    8'sd0,    8'sd0,    8'sd0,   8'hFF, 8'hFF, 1'b1};
        vecs[5] = '{-8'sd128, -8'sd128,  8'sd127,  8'sd127, 8'h00, 8'hFF, 1'b0};

        // Reset values
        repeat (3) @(posedge clk_20m);
        #1;
        checkOutput("reset_dout", dout, 0);
        checkOutput("reset_dout_vld", dout_vld, 0);
        checkOutput("reset_sym_last", dout_sym_last, 0);
        checkOutput("reset_sym_cnt", sym_cnt, 0);
        checkOutput("reset_idx_err", idx_err, 0);
        Rst_n_0 = 1'b1;
        idleCycles(2);

        // Index 28 followed by 30: error pulse, nothing emitted
        fillUniform(8'sd20, -8'sd20, 8'sd20, -8'sd20);
        e0 = errCount;
        for (int b = 0; b <= 28; b++) applyStimulus(b, symRe[b], symIm[b]);
        applyStimulus(30, symRe[30], symIm[30]);
        idleCycles(3);
        checkOutput("skip_idx_err_pulses", errCount - e0, 1);
        checkOutput("skip_sym_cnt", sym_cnt, 0);
        waitDrain("skip");

        // Clean symbol with output timing relative to bin 63
        vldCyc.delete();
        pushModel(12);
        driveSymbol(1'b0);
        waitDrain("timing");
        expSymCnt = 1;
        checkOutput("timing_sym_cnt", sym_cnt, expSymCnt);
        checkOutput("timing_nbytes", vldCyc.size(), 12);
        if (vldCyc.size() == 12) begin
            checkOutput("timing_byte6", vldCyc[5] - t63, 1);
            checkOutput("timing_byte7", vldCyc[6] - t63, 2);
            checkOutput("timing_byte12", vldCyc[11] - t63, 7);
        end

        // Table of uniform-per-half symbols
        for (int i = 0; i < 6; i++) begin
            fillUniform(vecs[i].reNeg, vecs[i].imNeg, vecs[i].rePos, vecs[i].imPos);
            for (int j = 0; j < 12; j++)
                expQ.push_back('{data: (j < 6) ? vecs[i].expNeg : vecs[i].expPos,
                                 last: (j == 11)});
            e0 = errCount;
            if (vecs[i].gaps) begin
                applyStimulus(5, 8'sd1, 8'sd1);
                applyStimulus(63, 8'sd1, 8'sd1);
            end
            driveSymbol(vecs[i].gaps);
            waitDrain("vec");
            expSymCnt++;
            checkOutput("vec_sym_cnt", sym_cnt, expSymCnt);
            checkOutput("vec_no_idx_err", errCount - e0, 0);
        end

        // Per-bin pattern exercising bit ordering across the symbol
        for (int b = 0; b < 64; b++) begin
            symRe[b] = (b % 3 == 0) ? -8'sd7 : 8'sd9;
            symIm[b] = (b % 5 < 2) ? -8'sd3 : 8'sd3;
        end
        pushModel(12);
        driveSymbol(1'b0);
        waitDrain("pattern");
        expSymCnt++;
        checkOutput("pattern_sym_cnt", sym_cnt, expSymCnt);

        // Break at bin 45 with index 0 restarts a symbol immediately
        e0 = errCount;
        pushModel(1);
        for (int b = 0; b <= 44; b++) applyStimulus(b, symRe[b], symIm[b]);
        pushModel(12);
        driveSymbol(1'b0);
        waitDrain("restart");
        expSymCnt++;
        checkOutput("restart_idx_err", errCount - e0, 1);
        checkOutput("restart_sym_cnt", sym_cnt, expSymCnt);

`ifdef OFDM_DEMAP_PILOT_OUT_EN
        // Pilot export in arrival order 7, 21, 43, 57
        pilotQ.delete();
        symRe[7]  =  8'sd100; symIm[7]  = -8'sd100;
        symRe[21] = -8'sd100; symIm[21] =  8'sd100;
        symRe[43] =  8'sd100; symIm[43] =  8'sd100;
        symRe[57] = -8'sd100; symIm[57] = -8'sd100;
        pushModel(12);
        driveSymbol(1'b0);
        waitDrain("pilot");
        expSymCnt++;
        checkOutput("pilot_count", pilotQ.size(), 4);
        if (pilotQ.size() == 4) begin
            checkOutput("pilot0", pilotQ[0], {2'd2, 8'd100, 8'h9C});
            checkOutput("pilot1", pilotQ[1], {2'd3, 8'h9C, 8'd100});
            checkOutput("pilot2", pilotQ[2], {2'd0, 8'd100, 8'd100});
            checkOutput("pilot3", pilotQ[3], {2'd1, 8'h9C, 8'h9C});
        end
`endif

        // Reset asserted at T63+3 aborts the drain
        fillUniform(8'sd20, -8'sd20, 8'sd20, -8'sd20);
        pushModel(12);
        driveSymbol(1'b0);
        while (cyc < t63 + 3) begin
            @(posedge clk_20m);
            #1;
        end
        Rst_n_0 = 1'b0;
        expQ.delete();
        expSymCnt = 0;
        #1;
        checkOutput("rst_mid_dout_vld", dout_vld, 0);
        checkOutput("rst_mid_sym_last", dout_sym_last, 0);
        checkOutput("rst_mid_sym_cnt", sym_cnt, expSymCnt);
        idleCycles(2);
        Rst_n_0 = 1'b1;
        idleCycles(10);
        checkOutput("rst_after_sym_cnt", sym_cnt, expSymCnt);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
